// File: rtl/wdg_pkg.sv
// Shared types and constants for the windowed watchdog.
`default_nettype none

package wdg_pkg;

  localparam int unsigned WDG_W = 16;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'b00,
    ST_CLOSED   = 2'b01,
    ST_OPEN     = 2'b10,
    ST_RESET    = 2'b11
  } wdg_state_e;

endpackage

`default_nettype wire

// File: rtl/wdg_prescaler.sv
// Window-tick prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
`default_nettype none

module wdg_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == C_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/window_watchdog_core.sv
// Windowed watchdog: closed window (service forbidden) then open window (service required),
// counting early/late errors and requesting a system reset when the error limit is reached.
`default_nettype none

module window_watchdog_core
  import wdg_pkg::*;
#(
  parameter int TICK_DIV  = 1000,
  parameter int RST_PULSE = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INIT,
  input  logic             WDSRVC,
  input  logic [WDG_W-1:0] FWLEN,
  input  logic [WDG_W-1:0] SWLEN,
  input  logic [WDG_W-1:0] RST_LMT,
  output logic             WD_RST,
  output logic             SRVC_OK,
  output logic             ERR_EARLY,
  output logic             ERR_LATE,
  output logic [WDG_W-1:0] ERR_CNT,
  output logic [1:0]       WIN_STATE
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PW-1:0] C_PULSE_LAST = PW'(RST_PULSE - 1);

  wdg_state_e       state_q, state_d;
  logic             srvc_prev_q;
  logic [WDG_W-1:0] len_q, len_d;
  logic [WDG_W-1:0] win_q, win_d;
  logic [WDG_W-1:0] err_q, err_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             wd_rst_q, wd_rst_d;
  logic             ok_q, ok_d;
  logic             early_q, early_d;
  logic             late_q, late_d;

  logic             w_evt;
  logic             w_tick;
  logic             w_expire;
  logic             w_restart;
  logic             w_do_err;
  logic             w_presc_clr;
  logic [WDG_W-1:0] w_err_inc;
  logic [WDG_W-1:0] w_lmt;

  assign w_evt     = WDSRVC & ~srvc_prev_q;
  // A zero-length window expires on its first cycle regardless of the tick.
  assign w_expire  = (len_q == '0) || (w_tick && (win_q == (len_q - 16'd1)));
  assign w_err_inc = (err_q == 16'hFFFF) ? err_q : (err_q + 16'd1);
  assign w_lmt     = (RST_LMT == '0) ? 16'd1 : RST_LMT;

  assign w_presc_clr = w_restart | (state_q == ST_DISABLED) | (state_q == ST_RESET);

  wdg_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLK    (CLK),
    .RST    (RST),
    .clr_i  (w_presc_clr),
    .tick_o (w_tick)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    err_d     = err_q;
    ok_d      = 1'b0;
    early_d   = 1'b0;
    late_d    = 1'b0;
    w_restart = 1'b0;
    w_do_err  = 1'b0;

    case (state_q)
      ST_DISABLED: begin
        if (INIT) begin
          state_d   = ST_CLOSED;
          len_d     = FWLEN;
          w_restart = 1'b1;
        end
      end
      ST_CLOSED: begin
        if (!INIT) begin
          state_d   = ST_DISABLED;
          w_restart = 1'b1;
        end else if (w_evt) begin
          early_d  = 1'b1;
          w_do_err = 1'b1;
        end else if (w_expire) begin
          state_d   = ST_OPEN;
          len_d     = SWLEN;
          w_restart = 1'b1;
        end
      end
      ST_OPEN: begin
        if (!INIT) begin
          state_d   = ST_DISABLED;
          w_restart = 1'b1;
        end else if (w_evt) begin
          ok_d      = 1'b1;
          err_d     = (err_q == '0) ? '0 : (err_q - 16'd1);
          state_d   = ST_CLOSED;
          len_d     = FWLEN;
          w_restart = 1'b1;
        end else if (w_expire) begin
          late_d   = 1'b1;
          w_do_err = 1'b1;
        end
      end
      ST_RESET: begin
        // Service and INIT are ignored here so the reset pulse always completes.
        if (pcnt_q == C_PULSE_LAST) begin
          err_d     = '0;
          len_d     = FWLEN;
          w_restart = 1'b1;
          state_d   = INIT ? ST_CLOSED : ST_DISABLED;
        end
      end
      default: begin
        state_d = ST_DISABLED;
      end
    endcase

    if (w_do_err) begin
      err_d     = w_err_inc;
      w_restart = 1'b1;
      if (w_err_inc >= w_lmt) begin
        state_d = ST_RESET;
      end else begin
        state_d = ST_CLOSED;
        len_d   = FWLEN;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (w_restart || (state_q == ST_DISABLED) || (state_q == ST_RESET)) begin
      win_d = '0;
    end else if (w_tick) begin
      win_d = win_q + 16'd1;
    end
  end

  assign pcnt_d   = ((state_q == ST_RESET) && (state_d == ST_RESET)) ? (pcnt_q + PW'(1)) : '0;
  assign wd_rst_d = (state_d == ST_RESET);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_DISABLED;
      srvc_prev_q <= 1'b0;
      len_q       <= '0;
      win_q       <= '0;
      err_q       <= '0;
      pcnt_q      <= '0;
      wd_rst_q    <= 1'b0;
      ok_q        <= 1'b0;
      early_q     <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      srvc_prev_q <= WDSRVC;
      len_q       <= len_d;
      win_q       <= win_d;
      err_q       <= err_d;
      pcnt_q      <= pcnt_d;
      wd_rst_q    <= wd_rst_d;
      ok_q        <= ok_d;
      early_q     <= early_d;
      late_q      <= late_d;
    end
  end

  assign WD_RST    = wd_rst_q;
  assign SRVC_OK   = ok_q;
  assign ERR_EARLY = early_q;
  assign ERR_LATE  = late_q;
  assign ERR_CNT   = err_q;
  assign WIN_STATE = state_q;

endmodule

`default_nettype wire

// File: tb/tb_window_watchdog_core.sv
// Scoreboard bench: stimulus queues expected output events, a monitor compares each observed event.
`default_nettype none

module tb_window_watchdog_core;

  logic        CLK;
  logic        RST;
  logic        INIT;
  logic        WDSRVC;
  logic [15:0] FWLEN;
  logic [15:0] SWLEN;
  logic [15:0] RST_LMT;
  logic        WD_RST;
  logic        SRVC_OK;
  logic        ERR_EARLY;
  logic        ERR_LATE;
  logic [15:0] ERR_CNT;
  logic [1:0]  WIN_STATE;

  window_watchdog_core #(
    .TICK_DIV  (4),
    .RST_PULSE (3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .INIT      (INIT),
    .WDSRVC    (WDSRVC),
    .FWLEN     (FWLEN),
    .SWLEN     (SWLEN),
    .RST_LMT   (RST_LMT),
    .WD_RST    (WD_RST),
    .SRVC_OK   (SRVC_OK),
    .ERR_EARLY (ERR_EARLY),
    .ERR_LATE  (ERR_LATE),
    .ERR_CNT   (ERR_CNT),
    .WIN_STATE (WIN_STATE)
  );

  typedef struct {
    logic [1:0]  st;
    logic        ok;
    logic        early;
    logic        late;
    logic        wdrst;
    logic [15:0] cnt;
    int          gap;
  } evt_t;

  evt_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic go(input int k);
    while (cyc < k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] st, input logic ok, input logic early, input logic late,
                      input logic wdrst, input logic [15:0] cnt, input int gap);
    evt_t e;
    e.st = st; e.ok = ok; e.early = early; e.late = late;
    e.wdrst = wdrst; e.cnt = cnt; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: an event is any state/count/WD_RST change or any pulse; gap = cycles since the last event.
  logic [1:0]  p_st;
  logic        p_rst;
  logic [15:0] p_cnt;
  bit          seen = 1'b0;
  int          gap  = 0;
  int          nevt = 0;

  initial begin
    evt_t e;
    bit   evt;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        gap++;
        evt = !seen || (WIN_STATE != p_st) || SRVC_OK || ERR_EARLY || ERR_LATE ||
              (WD_RST != p_rst) || (ERR_CNT != p_cnt);
        if (!seen) gap = 0;
        if (evt) begin
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL evt%0d unexpected: got st=%b ok=%b ee=%b el=%b rst=%b cnt=%0d gap=%0d, required none",
                     nevt, WIN_STATE, SRVC_OK, ERR_EARLY, ERR_LATE, WD_RST, ERR_CNT, gap);
          end else begin
            e = exp_q.pop_front();
            if (WIN_STATE === e.st && SRVC_OK === e.ok && ERR_EARLY === e.early &&
                ERR_LATE === e.late && WD_RST === e.wdrst && ERR_CNT === e.cnt && gap == e.gap) begin
              passes++;
            end else begin
              $display("FAIL evt%0d: got st=%b ok=%b ee=%b el=%b rst=%b cnt=%0d gap=%0d, required st=%b ok=%b ee=%b el=%b rst=%b cnt=%0d gap=%0d",
                       nevt, WIN_STATE, SRVC_OK, ERR_EARLY, ERR_LATE, WD_RST, ERR_CNT, gap,
                       e.st, e.ok, e.early, e.late, e.wdrst, e.cnt, e.gap);
            end
          end
          nevt++;
          gap = 0;
        end
        seen  = 1'b1;
        p_st  = WIN_STATE;
        p_rst = WD_RST;
        p_cnt = ERR_CNT;
      end
    end
  end

  initial begin
    RST = 1'b1; INIT = 1'b0; WDSRVC = 1'b0;
    FWLEN = 16'd2; SWLEN = 16'd3; RST_LMT = 16'd4;

    // Reset state, then enable: CLOSED 8 cycles (2 ticks x 4), then OPEN.
    go(2);
    RST = 1'b0; INIT = 1'b1; mon_en = 1'b1;
    push(2'b00, 0, 0, 0, 0, 16'd0, 0);
    push(2'b01, 0, 0, 0, 0, 16'd0, 1);
    push(2'b10, 0, 0, 0, 0, 16'd0, 8);

    // Service after first OPEN tick: accepted, count stays 0, full CLOSED follows.
    go(16); WDSRVC = 1'b1;
    push(2'b01, 1, 0, 0, 0, 16'd0, 6);
    push(2'b10, 0, 0, 0, 0, 16'd0, 8);
    go(17); WDSRVC = 1'b0;

    go(26); WDSRVC = 1'b1;
    push(2'b01, 1, 0, 0, 0, 16'd0, 2);
    go(27); WDSRVC = 1'b0;

    // Service 3 cycles into CLOSED: early error, CLOSED restarts for a full 8 cycles.
    go(29); WDSRVC = 1'b1;
    push(2'b01, 0, 1, 0, 0, 16'd1, 3);
    push(2'b10, 0, 0, 0, 0, 16'd1, 8);
    go(30); WDSRVC = 1'b0;

    // Service sampled on the OPEN expiry cycle: accepted, 1 -> 0.
    go(49); WDSRVC = 1'b1;
    push(2'b01, 1, 0, 0, 0, 16'd0, 12);
    push(2'b10, 0, 0, 0, 0, 16'd0, 8);

    // No service with RST_LMT=2 and FWLEN=0: two late errors, then a 3-cycle reset.
    go(50); WDSRVC = 1'b0; FWLEN = 16'd0; RST_LMT = 16'd2;
    push(2'b01, 0, 0, 1, 0, 16'd1, 12);
    push(2'b10, 0, 0, 0, 0, 16'd1, 1);
    push(2'b11, 0, 0, 1, 1, 16'd2, 12);
    push(2'b01, 0, 0, 0, 0, 16'd0, 3);
    push(2'b10, 0, 0, 0, 0, 16'd0, 1);

    // INIT dropped mid-OPEN: DISABLED next cycle, no error.
    go(90); INIT = 1'b0; RST_LMT = 16'd0; FWLEN = 16'd2;
    push(2'b00, 0, 0, 0, 0, 16'd0, 4);

    // RST_LMT=0: first (early) error resets; INIT dropped during RESET.
    go(92); INIT = 1'b1;
    push(2'b01, 0, 0, 0, 0, 16'd0, 2);
    go(94); WDSRVC = 1'b1;
    push(2'b11, 0, 1, 0, 1, 16'd1, 2);
    push(2'b00, 0, 0, 0, 0, 16'd0, 3);
    go(95); WDSRVC = 1'b0; INIT = 1'b0;

    // Build ERR_CNT=1 in OPEN, then assert RST mid-OPEN.
    go(98); INIT = 1'b1; RST_LMT = 16'd4; FWLEN = 16'd0;
    push(2'b01, 0, 0, 0, 0, 16'd0, 1);
    push(2'b10, 0, 0, 0, 0, 16'd0, 1);
    push(2'b01, 0, 0, 1, 0, 16'd1, 12);
    push(2'b10, 0, 0, 0, 0, 16'd1, 1);
    go(115); RST = 1'b1;
    push(2'b00, 0, 0, 0, 0, 16'd0, 3);
    go(116); RST = 1'b0; INIT = 1'b0;

    go(126);
    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL pending_events: got %0d still expected, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
